filter_line_buf: RTL and testbench



---
 rtl/filter_pkg.sv | 38 +++
 rtl/filter_lb_ram.sv | 42 ++++
 rtl/filter_line_buf.sv | 126 ++++++++++++
 tb/tb_filter_line_buf.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/filter_pkg.sv
`default_nettype none
// ============================================================================
// Package : filter_pkg
// Shared constants and helpers for the 3x3 image-filter line buffer.
// Revision: 1.0 - initial release
// ============================================================================
package filter_pkg;

    localparam int DW       = 8;     // pixel width
    localparam int DEPTH    = 1920;  // words per line bank
    localparam int AW       = 12;    // column address width
    localparam int NUM_BANK = 4;     // rotating line banks
    localparam int BANK_W   = 2;     // bank index width

    // True when exactly one bank-enable bit is set
    function automatic logic onehot_legal(input logic [NUM_BANK-1:0] v);
        logic [2:0] cnt;
        cnt = '0;
        for (int i = 0; i < NUM_BANK; i++) begin
            cnt = cnt + {2'b00, v[i]};
        end
        return (cnt == 3'd1);
    endfunction

    // Index of the set bit; meaningful only for a legal one-hot value
    function automatic logic [BANK_W-1:0] onehot_to_idx(input logic [NUM_BANK-1:0] v);
        logic [BANK_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < NUM_BANK; i++) begin
            if (v[i]) begin
                idx = idx | BANK_W'(i);
            end
        end
        return idx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/filter_lb_ram.sv
`default_nettype none
// ============================================================================
// Module  : filter_lb_ram
// Simple dual-port RAM, DEPTH x DW, one write port and a registered read port.
// Read data holds its value while the read port is idle.
// Revision: 1.0 - initial release
// ============================================================================
module filter_lb_ram #(
    parameter int DW    = 8,
    parameter int DEPTH = 1920,
    parameter int AW    = 11
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [DW-1:0] i_wdata,
    input  logic          i_re,
    input  logic [AW-1:0] i_raddr,
    output logic [DW-1:0] o_rdata
);

    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] rdata_q;

    // Storage write; contents are intentionally not reset
    always_ff @(posedge clk) begin
        if (i_we) begin
            mem[i_waddr] <= i_wdata;
        end
    end

    // Registered read, held when no read is requested
    always_ff @(posedge clk) begin
        if (i_re) begin
            rdata_q <= mem[i_raddr];
        end
    end

    assign o_rdata = rdata_q;

endmodule
`default_nettype wire

// File: rtl/filter_line_buf.sv
`default_nettype none
// ============================================================================
// Module  : filter_line_buf
// Four rotating line banks; presents the three most recently completed lines
// (top/mid/bot) column-aligned with a two-cycle read latency.
// Revision: 1.0 - initial release
// ============================================================================
module filter_line_buf
    import filter_pkg::*;
#(
    parameter int DW    = filter_pkg::DW,
    parameter int DEPTH = filter_pkg::DEPTH,
    parameter int AW    = filter_pkg::AW
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic [NUM_BANK-1:0] i_mem_wen,
    input  logic                i_mem_ren,
    input  logic [AW-1:0]       i_mem_addr,
    input  logic [DW-1:0]       i_pixel,
    output logic [DW-1:0]       o_top,
    output logic [DW-1:0]       o_mid,
    output logic [DW-1:0]       o_bot,
    output logic                o_valid,
    output logic                o_err
);

    // RAM index width; the full address is still range-checked against DEPTH
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic                       addr_ok;
    logic                       wen_any;
    logic                       wen_legal;
    logic                       wr_ok;
    logic                       rd_ok;
    logic                       err_now;
    logic [BANK_W-1:0]          wr_idx;
    logic [BANK_W-1:0]          act_bank;
    logic [BANK_W-1:0]          wr_bank_d;
    logic [BANK_W-1:0]          wr_bank_q;
    logic [BANK_W-1:0]          act_q;
    logic                       vld1_q;
    logic                       valid_q;
    logic                       err_q;
    logic [DW-1:0]              top_q;
    logic [DW-1:0]              mid_q;
    logic [DW-1:0]              bot_q;
    logic [BANK_W-1:0]          top_sel;
    logic [BANK_W-1:0]          mid_sel;
    logic [BANK_W-1:0]          bot_sel;
    logic [NUM_BANK-1:0][DW-1:0] rd_data;

    // Decode of the FSM command: legality, bank in use and error condition
    always_comb begin
        addr_ok   = (32'(i_mem_addr) < 32'(DEPTH));
        wen_any   = |i_mem_wen;
        wen_legal = onehot_legal(i_mem_wen);
        wr_idx    = onehot_to_idx(i_mem_wen);
        wr_ok     = wen_legal && addr_ok;
        rd_ok     = i_mem_ren && addr_ok;
        // The bank being written this cycle counts as newest, so it is never read out
        act_bank  = wr_ok ? wr_idx : wr_bank_q;
        wr_bank_d = act_bank;
        err_now   = (wen_any && !wen_legal) || ((wen_any || i_mem_ren) && !addr_ok);
    end

    generate
        for (genvar b = 0; b < NUM_BANK; b++) begin : g_bank
            filter_lb_ram #(
                .DW    (DW),
                .DEPTH (DEPTH),
                .AW    (IW)
            ) u_ram (
                .clk     (clk),
                .i_we    (wr_ok && i_mem_wen[b]),
                .i_waddr (i_mem_addr[IW-1:0]),
                .i_wdata (i_pixel),
                .i_re    (rd_ok),
                .i_raddr (i_mem_addr[IW-1:0]),
                .o_rdata (rd_data[b])
            );
        end
    endgenerate

    // Bank ordering relative to the bank that was active at the read cycle
    always_comb begin
        bot_sel = act_q - BANK_W'(1);
        mid_sel = act_q - BANK_W'(2);
        top_sel = act_q - BANK_W'(3);
    end

    // Write-bank tracking, read pipeline, output registers and sticky error
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_bank_q <= BANK_W'(3);
            act_q     <= '0;
            vld1_q    <= 1'b0;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
            top_q     <= '0;
            mid_q     <= '0;
            bot_q     <= '0;
        end else begin
            wr_bank_q <= wr_bank_d;
            vld1_q    <= rd_ok;
            valid_q   <= vld1_q;
            err_q     <= err_q || err_now;
            if (rd_ok) begin
                act_q <= act_bank;
            end
            if (vld1_q) begin
                top_q <= rd_data[top_sel];
                mid_q <= rd_data[mid_sel];
                bot_q <= rd_data[bot_sel];
            end
        end
    end

    assign o_top   = top_q;
    assign o_mid   = mid_q;
    assign o_bot   = bot_q;
    assign o_valid = valid_q;
    assign o_err   = err_q;

endmodule
`default_nettype wire

// File: tb/tb_filter_line_buf.sv
`default_nettype none
// ============================================================================
// Module  : tb_filter_line_buf
// Directed self-checking bench for filter_line_buf (DW=8, DEPTH=16, AW=5).
// Revision: 1.0 - initial release
// ============================================================================
module tb_filter_line_buf;

    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int AW    = 5;

    logic          clk;
    logic          rstn;
    logic [3:0]    i_mem_wen;
    logic          i_mem_ren;
    logic [AW-1:0] i_mem_addr;
    logic [DW-1:0] i_pixel;
    logic [DW-1:0] o_top;
    logic [DW-1:0] o_mid;
    logic [DW-1:0] o_bot;
    logic          o_valid;
    logic          o_err;

    int checks;
    int errors;
    int vcount;

    filter_line_buf #(
        .DW    (DW),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .i_mem_wen  (i_mem_wen),
        .i_mem_ren  (i_mem_ren),
        .i_mem_addr (i_mem_addr),
        .i_pixel    (i_pixel),
        .o_top      (o_top),
        .o_mid      (o_mid),
        .o_bot      (o_bot),
        .o_valid    (o_valid),
        .o_err      (o_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [7:0] t, input logic [7:0] m, input logic [7:0] b);
        chk({tag, "_top"}, 32'(o_top), 32'(t));
        chk({tag, "_mid"}, 32'(o_mid), 32'(m));
        chk({tag, "_bot"}, 32'(o_bot), 32'(b));
    endtask

    task automatic idle();
        i_mem_wen  = 4'b0000;
        i_mem_ren  = 1'b0;
        i_mem_addr = '0;
        i_pixel    = '0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        vcount = 0;
        rstn   = 1'b0;
        idle();

        // Reset state
        step();
        step();
        chk("rst_valid", 32'(o_valid), 32'd0);
        chk("rst_err",   32'(o_err),   32'd0);
        chk_out("rst", 8'h00, 8'h00, 8'h00);
        rstn = 1'b1;
        step();

        // Lines 0..2 into banks 0..2, pixel = line*16 + addr
        for (int l = 0; l < 3; l++) begin
            for (int a = 0; a < DEPTH; a++) begin
                i_mem_wen  = 4'b0001 << l;
                i_mem_addr = AW'(a);
                i_pixel    = 8'(l * 16 + a);
                step();
            end
        end

        // Line 3 into bank 3 while reading column 5
        for (int a = 0; a < DEPTH; a++) begin
            i_mem_wen  = 4'b1000;
            i_mem_addr = AW'(a);
            i_pixel    = 8'(8'h30 + a);
            i_mem_ren  = (a == 5);
            step();
            if (a == 5) chk("basic_lat1_valid", 32'(o_valid), 32'd0);
            if (a == 6) begin
                chk("basic_valid", 32'(o_valid), 32'd1);
                chk_out("basic", 8'h05, 8'h15, 8'h25);
            end
            if (a == 7) chk("basic_pulse_valid", 32'(o_valid), 32'd0);
        end

        // Wrap: line 4 into bank 0 (0x3x) while reading column 7
        for (int a = 0; a < DEPTH; a++) begin
            i_mem_wen  = 4'b0001;
            i_mem_addr = AW'(a);
            i_pixel    = 8'(8'h30 + a);
            i_mem_ren  = (a == 7);
            step();
            if (a == 8) begin
                chk("wrap_valid", 32'(o_valid), 32'd1);
                chk_out("wrap", 8'h17, 8'h27, 8'h37);
            end
        end
        idle();
        step();
        chk("wrap_err", 32'(o_err), 32'd0);

        // Streaming: columns 0..15 back to back, last write was bank 0
        for (int k = 0; k < 20; k++) begin
            i_mem_ren  = (k < DEPTH);
            i_mem_addr = (k < DEPTH) ? AW'(k) : '0;
            step();
            chk("stream_valid", 32'(o_valid), ((k >= 1) && (k <= DEPTH)) ? 32'd1 : 32'd0);
            if (o_valid) begin
                vcount++;
                chk_out("stream", 8'(8'h10 + k - 1), 8'(8'h20 + k - 1), 8'(8'h30 + k - 1));
            end
        end
        chk("stream_count", 32'(vcount), 32'd16);
        idle();

        // Illegal write enable: error flag, no write, bank tracking unchanged
        i_mem_wen  = 4'b0101;
        i_mem_addr = AW'(3);
        i_pixel    = 8'hAA;
        step();
        idle();
        chk("illwen_err", 32'(o_err), 32'd1);
        i_mem_ren  = 1'b1;
        i_mem_addr = AW'(3);
        step();
        idle();
        step();
        chk("illwen_valid", 32'(o_valid), 32'd1);
        chk_out("illwen", 8'h13, 8'h23, 8'h33);

        // Reset one cycle after a read: pipeline flushed, outputs cleared
        i_mem_ren  = 1'b1;
        i_mem_addr = AW'(4);
        step();
        idle();
        rstn = 1'b0;
        #1;
        chk("rstmid_valid", 32'(o_valid), 32'd0);
        chk("rstmid_err",   32'(o_err),   32'd0);
        chk_out("rstmid", 8'h00, 8'h00, 8'h00);
        step();
        step();
        rstn = 1'b1;
        step();
        chk("rstmid_after1_valid", 32'(o_valid), 32'd0);
        step();
        chk("rstmid_after2_valid", 32'(o_valid), 32'd0);

        // First write after reset to bank 0, with a read: bot must be bank 3
        i_mem_wen  = 4'b0001;
        i_mem_ren  = 1'b1;
        i_mem_addr = AW'(2);
        i_pixel    = 8'h77;
        step();
        idle();
        step();
        chk("post_rst_valid", 32'(o_valid), 32'd1);
        chk_out("post_rst", 8'h12, 8'h22, 8'h32);
        chk("post_rst_err", 32'(o_err), 32'd0);

        // Out-of-range read: error, no valid, outputs hold
        i_mem_ren  = 1'b1;
        i_mem_addr = AW'(16);
        step();
        idle();
        chk("oor_err", 32'(o_err), 32'd1);
        step();
        chk("oor_valid", 32'(o_valid), 32'd0);
        chk_out("oor_hold", 8'h12, 8'h22, 8'h32);
        step();
        chk("oor_valid2", 32'(o_valid), 32'd0);
        chk("oor_err_sticky", 32'(o_err), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
